pkt_in_arbiter: RTL

- Round-robin arbiter that merges NUM_INPUTS independent valid/ready packet streams into the single assembled-packet input of the packet router.
- Typical sources: peripheral input pipes and diagnostic injection.
- Per-input enables come from the register bank.
- Provides one registered output stage and per-input accepted-packet counters for diagnostics.

---
 rtl/pkt_in_arbiter.sv | 52 +++++
 1 files changed

// File: rtl/pkt_in_arbiter.sv
// pkt_in_arbiter: round-robin merge of NUM_INPUTS packet streams into one registered output stage
module pkt_in_arbiter #(
    parameter int PACKET_BITS = 72,
    parameter int NUM_INPUTS = 4,
    parameter int CNT_BITS = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         en_in,
    input  logic [PACKET_BITS-1:0]        pkt_in_data_in [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0]         pkt_in_vld_in,
    output logic [NUM_INPUTS-1:0]         pkt_in_rdy_out,
    output logic [PACKET_BITS-1:0]        pkt_out_data_out,
    output logic                          pkt_out_vld_out,
    input  logic                          pkt_out_rdy_in,
    output logic [CNT_BITS-1:0]           pkt_cnt_out [NUM_INPUTS],
    output logic [$clog2(NUM_INPUTS)-1:0] last_grant_out
);
    localparam int PW = $clog2(NUM_INPUTS);
    logic [NUM_INPUTS-1:0] req, grant;
    logic [PW-1:0] win, idx;
    logic free, accept;
    assign req = pkt_in_vld_in & en_in;
    assign free = ~pkt_out_vld_out | pkt_out_rdy_in;
    assign pkt_in_rdy_out = grant & {NUM_INPUTS{free & ~reset}};
    assign accept = |pkt_in_rdy_out;
    always_comb begin
        grant = '0;
        win = last_grant_out;
        idx = last_grant_out;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            idx = PW'((int'(last_grant_out) + k) % NUM_INPUTS);
            win = req[idx] ? idx : win;
        end
        grant[win] = req[win];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_out_vld_out <= 1'b0;
            pkt_out_data_out <= '0;
            last_grant_out <= PW'(NUM_INPUTS - 1);
            for (int i = 0; i < NUM_INPUTS; i++) pkt_cnt_out[i] <= '0;
        end else if (accept) begin
            pkt_out_vld_out <= 1'b1;
            pkt_out_data_out <= pkt_in_data_in[win];
            last_grant_out <= win;
            pkt_cnt_out[win] <= pkt_cnt_out[win] + 1'b1;
        end else if (pkt_out_rdy_in) begin
            pkt_out_vld_out <= 1'b0;
        end
    end
endmodule
